// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and constants for the stall/flush hazard controller.
// Holds the wait FSM state enum, register index width and x0 index.
package hazard_stall_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

    localparam int REG_W = 5;

    localparam logic [REG_W-1:0] X0_IDX = '0;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side bundle for the stall/flush hazard controller.
// slave: controller side (hazard inputs in, stall/flush/status out).
// master: pipeline side (drives hazard inputs, observes controls).
interface hazard_stall_ctrl_if #(
    parameter int NUM_REGS = 32
);
    import hazard_stall_ctrl_pkg::*;

    logic             IssueD;
    logic             RegWriteD;
    logic [REG_W-1:0] RD_D;
    logic [REG_W-1:0] Rs1_D;
    logic [REG_W-1:0] Rs2_D;
    logic             RegWriteE;
    logic             LoadE;
    logic [REG_W-1:0] RD_E;
    logic             PCSrcE;
    logic             MemReqM;
    logic             MemReadyM;
    logic             RegWriteW;
    logic [REG_W-1:0] RD_W;

    logic                StallF;
    logic                StallD;
    logic                StallE;
    logic                StallM;
    logic                FlushD;
    logic                FlushE;
    logic                BubbleW;
    logic [NUM_REGS-1:0] PendingMask;
    logic                MemTimeout;
    logic                SbError;

    modport master (
        output IssueD, RegWriteD, RD_D, Rs1_D, Rs2_D,
        output RegWriteE, LoadE, RD_E, PCSrcE,
        output MemReqM, MemReadyM, RegWriteW, RD_W,
        input  StallF, StallD, StallE, StallM,
        input  FlushD, FlushE, BubbleW,
        input  PendingMask, MemTimeout, SbError
    );

    modport slave (
        input  IssueD, RegWriteD, RD_D, Rs1_D, Rs2_D,
        input  RegWriteE, LoadE, RD_E, PCSrcE,
        input  MemReqM, MemReadyM, RegWriteW, RD_W,
        output StallF, StallD, StallE, StallM,
        output FlushD, FlushE, BubbleW,
        output PendingMask, MemTimeout, SbError
    );

endinterface

// File: rtl/hazard_stall_ctrl_sb_counter.sv
// Saturating up/down pending-write counter for one register.
// Ports: clk, rst, inc_i, dec_i, cnt_o (count), err_o (sticky over/underflow).
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             err_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            case ({inc_i, dec_i})
                2'b10: begin
                    if (cnt_q == CNT_MAX) err_q <= 1'b1;
                    else                  cnt_q <= cnt_q + 1'b1;
                end
                2'b01: begin
                    if (cnt_q == '0) err_q <= 1'b1;
                    else             cnt_q <= cnt_q - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign cnt_o = cnt_q;
    assign err_o = err_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush generation for F/D/E/M plus pending-write scoreboard.
// Ports: clk, rst (async active-high), hz (slave side of the hazard bundle).
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 2,
    parameter int WAIT_MAX = 255
) (
    input  logic               clk,
    input  logic               rst,
    hazard_stall_ctrl_if.slave hz
);

    localparam int WAIT_W = $clog2(WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WMAX = WAIT_W'(WAIT_MAX);

    state_e            state_q;
    logic [WAIT_W-1:0] wait_q;
    logic              timeout_q;

    logic mem_wait;
    logic load_use;
    logic stall_fd, stall_em, flush_d, flush_e, bubble_w;

    assign mem_wait = hz.MemReqM & ~hz.MemReadyM;

    assign load_use = hz.LoadE & hz.RegWriteE
                    & (hz.RD_E != X0_IDX) & hz.IssueD
                    & ((hz.RD_E == hz.Rs1_D)
                     | (hz.RD_E == hz.Rs2_D));

    // Outputs are forced low while rst is high so a reset
    // during a wait drops the stalls without a clock edge.
    always_comb begin
        stall_fd = 1'b0;
        stall_em = 1'b0;
        flush_d  = 1'b0;
        flush_e  = 1'b0;
        bubble_w = 1'b0;
        if (!rst) begin
            if (mem_wait) begin
                stall_fd = 1'b1;
                stall_em = 1'b1;
                bubble_w = 1'b1;
            end else if (hz.PCSrcE) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if (load_use) begin
                stall_fd = 1'b1;
                flush_e  = 1'b1;
            end
        end
    end

    assign hz.StallF  = stall_fd;
    assign hz.StallD  = stall_fd;
    assign hz.StallE  = stall_em;
    assign hz.StallM  = stall_em;
    assign hz.FlushD  = flush_d;
    assign hz.FlushE  = flush_e;
    assign hz.BubbleW = bubble_w;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (mem_wait) state_q <= MEM_WAIT;
                end
                MEM_WAIT: begin
                    if (hz.MemReadyM) begin
                        state_q <= RUN;
                        wait_q  <= '0;
                    end else begin
                        if (wait_q != WMAX)
                            wait_q <= wait_q + 1'b1;
                        if (wait_q == WMAX - 1'b1)
                            timeout_q <= 1'b1;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign hz.MemTimeout = timeout_q;

    logic [NUM_REGS-1:0] err;

    assign err[0]            = 1'b0;
    assign hz.PendingMask[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_sb
        logic             inc;
        logic             dec;
        logic [CNT_W-1:0] cnt;

        assign inc = hz.IssueD & hz.RegWriteD
                   & (hz.RD_D == REG_W'(r))
                   & ~stall_fd & ~flush_e;
        assign dec = hz.RegWriteW
                   & (hz.RD_W == REG_W'(r))
                   & ~bubble_w;

        sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .inc_i (inc),
            .dec_i (dec),
            .cnt_o (cnt),
            .err_o (err[r])
        );

        assign hz.PendingMask[r] = |cnt;
    end

    assign hz.SbError = |err;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl.
// Vector table for stall/flush priority plus directed multi-cycle sequences.
module tb_hazard_stall_ctrl;
    import hazard_stall_ctrl_pkg::*;

    localparam int NREG  = 32;
    localparam int WMAXT = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    hazard_stall_ctrl_if #(.NUM_REGS(NREG)) hz ();

    hazard_stall_ctrl #(
        .NUM_REGS (NREG),
        .CNT_W    (2),
        .WAIT_MAX (WMAXT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz.slave)
    );

    int checks = 0;
    int errors = 0;

    // exp bit order: StallF StallD StallE StallM FlushD FlushE BubbleW
    typedef struct {
        logic       issue;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rde;
        logic       load;
        logic       rwe;
        logic       pcsrc;
        logic       req;
        logic       rdy;
        logic [6:0] exp;
    } vec_t;

    vec_t vt [12];

    function automatic logic [6:0] outs();
        return {hz.StallF, hz.StallD, hz.StallE, hz.StallM,
                hz.FlushD, hz.FlushE, hz.BubbleW};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        hz.IssueD    = 1'b0;
        hz.RegWriteD = 1'b0;
        hz.RD_D      = '0;
        hz.Rs1_D     = '0;
        hz.Rs2_D     = '0;
        hz.RegWriteE = 1'b0;
        hz.LoadE     = 1'b0;
        hz.RD_E      = '0;
        hz.PCSrcE    = 1'b0;
        hz.MemReqM   = 1'b0;
        hz.MemReadyM = 1'b0;
        hz.RegWriteW = 1'b0;
        hz.RD_W      = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
    endtask

    task automatic issue(input logic [4:0] rd, input logic ret);
        idle();
        hz.IssueD    = 1'b1;
        hz.RegWriteD = 1'b1;
        hz.RD_D      = rd;
        hz.RegWriteW = ret;
        hz.RD_W      = rd;
        cyc();
    endtask

    initial begin
        int stalled;
        vt[0]  = '{1, 5, 0, 5, 1, 1, 0, 0, 0, 7'b1100010};
        vt[1]  = '{1, 5, 0, 0, 0, 0, 0, 0, 0, 7'b0000000};
        vt[2]  = '{1, 1, 9, 9, 1, 1, 0, 0, 0, 7'b1100010};
        vt[3]  = '{1, 0, 0, 0, 1, 1, 0, 0, 0, 7'b0000000};
        vt[4]  = '{0, 5, 0, 5, 1, 1, 0, 0, 0, 7'b0000000};
        vt[5]  = '{1, 5, 0, 5, 1, 0, 0, 0, 0, 7'b0000000};
        vt[6]  = '{1, 5, 0, 5, 0, 1, 0, 0, 0, 7'b0000000};
        vt[7]  = '{1, 5, 0, 5, 1, 1, 1, 0, 0, 7'b0000110};
        vt[8]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 7'b0000110};
        vt[9]  = '{1, 5, 0, 5, 1, 1, 1, 1, 0, 7'b1111001};
        vt[10] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 7'b0000000};
        vt[11] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 7'b0000000};

        idle();
        rst = 1'b1;
        #2;
        chk("rst_outs", 32'(outs()), 0);
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        chk("rst_mask", hz.PendingMask, 0);
        chk("rst_tmo", 32'(hz.MemTimeout), 0);
        chk("rst_sberr", 32'(hz.SbError), 0);
        chk("rst_state", 32'(dut.state_q), 32'(RUN));
        cyc();

        for (int i = 0; i < 12; i++) begin
            hz.IssueD    = vt[i].issue;
            hz.Rs1_D     = vt[i].rs1;
            hz.Rs2_D     = vt[i].rs2;
            hz.RD_E      = vt[i].rde;
            hz.LoadE     = vt[i].load;
            hz.RegWriteE = vt[i].rwe;
            hz.PCSrcE    = vt[i].pcsrc;
            hz.MemReqM   = vt[i].req;
            hz.MemReadyM = vt[i].rdy;
            #2;
            chk($sformatf("vec%0d", i), 32'(outs()), 32'(vt[i].exp));
            cyc();
        end
        idle();
        chk("vec_state", 32'(dut.state_q), 32'(RUN));
        chk("vec_mask", hz.PendingMask, 0);

        stalled = 0;
        for (int i = 0; i < 4; i++) begin
            hz.MemReqM   = 1'b1;
            hz.MemReadyM = (i == 3);
            #2;
            if (outs() == 7'b1111001) stalled++;
            cyc();
        end
        idle();
        chk("wait3_cycles", 32'(stalled), 3);
        chk("wait3_state", 32'(dut.state_q), 32'(RUN));
        chk("wait3_tmo", 32'(hz.MemTimeout), 0);

        hz.MemReqM = 1'b1;
        for (int i = 0; i < WMAXT + 2; i++) begin
            cyc();
            if (i == 100) chk("tmo_early", 32'(hz.MemTimeout), 0);
        end
        chk("tmo_set", 32'(hz.MemTimeout), 1);
        hz.MemReadyM = 1'b1;
        cyc();
        idle();
        cyc();
        chk("tmo_sticky", 32'(hz.MemTimeout), 1);
        chk("tmo_state", 32'(dut.state_q), 32'(RUN));
        do_reset();
        chk("tmo_clr", 32'(hz.MemTimeout), 0);

        for (int i = 0; i < 3; i++) issue(5'd7, 1'b0);
        idle();
        chk("sb3_mask", 32'(hz.PendingMask[7]), 1);
        chk("sb3_err", 32'(hz.SbError), 0);
        issue(5'd7, 1'b0);
        idle();
        chk("sb4_mask", 32'(hz.PendingMask[7]), 1);
        chk("sb4_err", 32'(hz.SbError), 1);
        do_reset();
        chk("sb_rst_err", 32'(hz.SbError), 0);

        issue(5'd7, 1'b0);
        chk("sb1_mask", hz.PendingMask, 32'h80);
        issue(5'd7, 1'b1);
        chk("sb_same_mask", hz.PendingMask, 32'h80);
        idle();
        hz.RegWriteW = 1'b1;
        hz.RD_W      = 5'd7;
        cyc();
        chk("sb_ret_mask", hz.PendingMask, 0);
        chk("sb_ret_err", 32'(hz.SbError), 0);
        cyc();
        idle();
        chk("sb_under_err", 32'(hz.SbError), 1);
        do_reset();

        idle();
        hz.IssueD    = 1'b1;
        hz.RegWriteD = 1'b1;
        hz.RD_D      = 5'd4;
        hz.Rs1_D     = 5'd6;
        hz.RD_E      = 5'd6;
        hz.LoadE     = 1'b1;
        hz.RegWriteE = 1'b1;
        cyc();
        idle();
        chk("sb_stall_noinc", hz.PendingMask, 0);
        hz.RegWriteW = 1'b1;
        hz.RD_W      = 5'd9;
        hz.MemReqM   = 1'b1;
        cyc();
        idle();
        chk("sb_bubble_nodec", 32'(hz.SbError), 0);

        issue(5'd3, 1'b0);
        idle();
        hz.MemReqM = 1'b1;
        cyc();
        cyc();
        #2;
        chk("r6_state", 32'(dut.state_q), 32'(MEM_WAIT));
        chk("r6_pre_mask", hz.PendingMask, 32'h8);
        rst = 1'b1;
        #1;
        chk("r6_outs", 32'(outs()), 0);
        chk("r6_mask", hz.PendingMask, 0);
        chk("r6_st", 32'(dut.state_q), 32'(RUN));
        #2;
        rst = 1'b0;
        idle();
        cyc();
        chk("r6_after", 32'(outs()), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: sim time limit reached");
        $fatal(1);
    end

endmodule
